// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the multi-cycle mul/div companion.
//   - 3-bit operation encodings (muldiv_op_e)
//   - FSM state encodings (legacy-compatible localparams)
//   - default operand width
//   - small decode helpers used by the datapath
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_DIV   = 3'd0,
        OP_DIVU  = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5
    } muldiv_op_e;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DIV_ZERO = 3'd1;
    localparam logic [2:0] ST_DIV_ON   = 3'd2;
    localparam logic [2:0] ST_MUL      = 3'd3;
    localparam logic [2:0] ST_ACC      = 3'd4;
    localparam logic [2:0] ST_END      = 3'd5;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_acc(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    // Operations whose operands are treated as two's-complement.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_seq.
//   master (execute): drives start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i
//   slave  (muldiv) : drives result_o, ready_o, div_by_zero_o, busy_o, stallreq_o
// Signal names keep the execute-stage view (_i into muldiv, _o out of it).
interface muldiv_if #(
    parameter int WIDTH = muldiv_pkg::MULDIV_WIDTH
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   hilo_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 div_by_zero_o;
    logic                 busy_o;
    logic                 stallreq_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        input  result_o, ready_o, div_by_zero_o, busy_o, stallreq_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        output result_o, ready_o, div_by_zero_o, busy_o, stallreq_o
    );
endinterface

// File: rtl/muldiv_clz.sv
// muldiv_clz: leading-zero counter.
//   a_i   : WIDTH-bit value
//   cnt_o : number of leading zeros (CNT_W bits); WIDTH when a_i is all zero
module muldiv_clz #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic found;

    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && a_i[i]) begin
                cnt_o = CNT_W'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle DIV/DIVU (radix-2 restoring) and MADD/MADDU/MSUB/MSUBU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_if.slave (request from execute, result/ready/stall back)
// Result is {remainder, quotient} for divides and the new {HI,LO} for accumulates.
// Optional build macro MULDIV_EARLY_TERM_EN: skips the leading-zero iterations of
// a divide by pre-shifting the dividend magnitude (results unchanged).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);
    logic [2:0]         state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   dvd_q;      // dividend bits / quotient (div); multiplicand magnitude (acc)
    logic [WIDTH-1:0]   dvs_q;      // divisor / multiplier magnitude
    logic [WIDTH-1:0]   rem_q;      // partial remainder
    logic               neg_q;      // result (quotient or product) must be negated
    logic               rsign_q;    // remainder takes dividend sign
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
    logic               dbz_q;

    // Operand decode on the request side.
    logic               sign1, sign2, op_valid, accept;
    logic [WIDTH-1:0]   mag1, mag2;

    always_comb begin
        sign1    = op_is_signed(bus.op_i) & bus.opdata1_i[WIDTH-1];
        sign2    = op_is_signed(bus.op_i) & bus.opdata2_i[WIDTH-1];
        mag1     = sign1 ? -bus.opdata1_i : bus.opdata1_i;
        mag2     = sign2 ? -bus.opdata2_i : bus.opdata2_i;
        op_valid = op_is_div(bus.op_i) | op_is_acc(bus.op_i);
        accept   = (state == ST_IDLE) & bus.start_i & ~bus.annul_i & op_valid;
    end

    // Dividend load value and starting count.
`ifdef MULDIV_EARLY_TERM_EN
    logic [CNT_W-1:0] lz, lz_eff;

    muldiv_clz #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_clz (
        .a_i   (mag1),
        .cnt_o (lz)
    );

    // A zero dividend still runs one step so the exit condition stays uniform.
    always_comb begin
        lz_eff = (lz == CNT_W'(WIDTH)) ? CNT_W'(WIDTH - 1) : lz;
    end

    logic [WIDTH-1:0] dvd_load;
    logic [CNT_W-1:0] cnt_load;
    always_comb begin
        dvd_load = mag1 << lz_eff;
        cnt_load = lz_eff;
    end
`else
    logic [WIDTH-1:0] dvd_load;
    logic [CNT_W-1:0] cnt_load;
    always_comb begin
        dvd_load = mag1;
        cnt_load = '0;
    end
`endif

    // One restoring step. cand < 2*divisor, so the difference fits WIDTH bits.
    logic [WIDTH:0]     cand;
    logic               qbit;
    logic [WIDTH-1:0]   diff, rem_nxt, quo_nxt, rem_fix, quo_fix;
    logic [2*WIDTH-1:0] prod_mag;

    always_comb begin
        cand     = {rem_q, dvd_q[WIDTH-1]};
        qbit     = (cand >= {1'b0, dvs_q});
        diff     = cand[WIDTH-1:0] - dvs_q;
        rem_nxt  = qbit ? diff : cand[WIDTH-1:0];
        quo_nxt  = {dvd_q[WIDTH-2:0], qbit};
        quo_fix  = neg_q   ? -quo_nxt : quo_nxt;
        rem_fix  = rsign_q ? -rem_nxt : rem_nxt;
        prod_mag = {{WIDTH{1'b0}}, dvd_q} * {{WIDTH{1'b0}}, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            rsign_q  <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (bus.annul_i && state != ST_IDLE) begin
            state    <= ST_IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.op_i;
                        dvs_q   <= mag2;
                        neg_q   <= sign1 ^ sign2;
                        rsign_q <= sign1;
                        rem_q   <= '0;
                        if (op_is_div(bus.op_i)) begin
                            dvd_q <= dvd_load;
                            cnt_q <= cnt_load;
                            state <= (bus.opdata2_i == '0) ? ST_DIV_ZERO : ST_DIV_ON;
                        end else begin
                            dvd_q <= mag1;
                            state <= ST_MUL;
                        end
                    end
                end
                ST_DIV_ZERO: begin
                    result_q <= '0;
                    dbz_q    <= 1'b1;
                    ready_q  <= 1'b1;
                    state    <= ST_END;
                end
                ST_DIV_ON: begin
                    rem_q <= rem_nxt;
                    dvd_q <= quo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q <= {rem_fix, quo_fix};
                        dbz_q    <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= ST_END;
                    end
                end
                ST_MUL: begin
                    prod_q <= neg_q ? -prod_mag : prod_mag;
                    state  <= ST_ACC;
                end
                ST_ACC: begin
                    result_q <= op_is_sub(op_q) ? (bus.hilo_i - prod_q)
                                                : (bus.hilo_i + prod_q);
                    dbz_q    <= 1'b0;
                    ready_q  <= 1'b1;
                    state    <= ST_END;
                end
                ST_END: begin
                    if (!bus.start_i) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        dbz_q    <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic busy;
    always_comb begin
        busy = (state == ST_DIV_ON) || (state == ST_DIV_ZERO) ||
               (state == ST_MUL)    || (state == ST_ACC);
    end

    assign bus.busy_o        = busy;
    assign bus.stallreq_o    = busy | accept;
    assign bus.result_o      = result_q;
    assign bus.ready_o       = ready_q;
    assign bus.div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (WIDTH=32).
// Divide latencies follow the build: fixed WIDTH iterations, or with
// MULDIV_EARLY_TERM_EN, max(1, WIDTH-clz(|dividend|)) iterations.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] hilo);
        bus.op_i      = op;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.hilo_i    = hilo;
        bus.start_i   = 1'b1;
    endtask

    task automatic release_start();
        bus.start_i = 1'b0;
        tick();
    endtask

    // Cycles from acceptance until ready_o; -1 if it never arrives within max.
    task automatic wait_ready(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Expected divide latency from the dividend magnitude.
    function automatic int exp_div_lat(input logic [W-1:0] mag);
`ifdef MULDIV_EARLY_TERM_EN
        int z;
        int it;
        z = W;
        for (int i = 0; i < W; i++)
            if (mag[W-1-i] && z == W) z = i;
        it = W - z;
        if (it < 1) it = 1;
        return it + 1;
`else
        return (mag == 0) ? W + 1 : W + 1;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
        checks++; if (bus.result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
        checks++; if (bus.div_by_zero_o !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero_o); end
        checks++; if (bus.busy_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", bus.busy_o, bus.stallreq_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_div_signed();
        int  lat;
        int  exp_lat;
        logic bad;
        // 7 / -2 -> q=-3, r=1
        exp_lat = exp_div_lat(32'd7);
        drive(OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'd0);
        #1;
        checks++; if (bus.stallreq_o !== 1'b1) begin errors++; $display("FAIL div_stall_t: got %b want 1", bus.stallreq_o); end
        bad = 1'b0;
        for (int i = 1; i < exp_lat; i++) begin
            tick();
            if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL div_stall_window: got early ready/stall drop=%b want 0", bad); end
        tick();
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL div_ready_lat: got %b want 1 at t+%0d", bus.ready_o, exp_lat); end
        checks++; if (bus.result_o !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_7_m2: got %h want 00000001fffffffd", bus.result_o); end
        checks++; if (bus.div_by_zero_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL div_end_flags: got dbz=%b stall=%b want 0 0", bus.div_by_zero_o, bus.stallreq_o); end
        tick();
        checks++; if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_hold: got %b %h want 1 00000001fffffffd", bus.ready_o, bus.result_o); end
        release_start();
        checks++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin errors++; $display("FAIL div_clear: got %b %h want 0 0", bus.ready_o, bus.result_o); end
        // -7 / 2 -> q=-3, r=-1
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0);
        wait_ready(40, lat);
        checks++; if (lat != exp_div_lat(32'd7)) begin errors++; $display("FAIL div_m7_lat: got %0d want %0d", lat, exp_div_lat(32'd7)); end
        checks++; if (bus.result_o !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_m7_2: got %h want fffffffffffffffd", bus.result_o); end
        release_start();
    endtask

    task automatic test_divu();
        int lat;
        drive(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 64'd0);
        wait_ready(40, lat);
        checks++; if (lat != W + 1) begin errors++; $display("FAIL divu_lat: got %0d want %0d", lat, W + 1); end
        checks++; if (bus.result_o !== 64'h0000000F_0FFFFFFF) begin errors++; $display("FAIL divu_ffff_10: got %h want 0000000f0fffffff", bus.result_o); end
        release_start();
        // 5 / 2: early-term build finishes at t+4
        drive(OP_DIVU, 32'd5, 32'd2, 64'd0);
        wait_ready(40, lat);
        checks++; if (lat != exp_div_lat(32'd5)) begin errors++; $display("FAIL divu_5_2_lat: got %0d want %0d", lat, exp_div_lat(32'd5)); end
        checks++; if (bus.result_o !== 64'h00000001_00000002) begin errors++; $display("FAIL divu_5_2: got %h want 0000000100000002", bus.result_o); end
        release_start();
        // 0 / 3 -> {0,0}
        drive(OP_DIVU, 32'd0, 32'd3, 64'd0);
        wait_ready(40, lat);
        checks++; if (lat != exp_div_lat(32'd0) || bus.result_o !== 64'd0) begin errors++; $display("FAIL divu_zero_dvd: got lat=%0d %h want lat=%0d 0", lat, bus.result_o, exp_div_lat(32'd0)); end
        release_start();
    endtask

    task automatic test_div_zero();
        drive(OP_DIV, 32'd123, 32'd0, 64'd0);
        tick();
        checks++; if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL dz_t1: got ready=%b busy=%b want 0 1", bus.ready_o, bus.busy_o); end
        tick();
        checks++; if (bus.ready_o !== 1'b1 || bus.div_by_zero_o !== 1'b1) begin errors++; $display("FAIL dz_t2: got ready=%b dbz=%b want 1 1", bus.ready_o, bus.div_by_zero_o); end
        checks++; if (bus.result_o !== 64'd0) begin errors++; $display("FAIL dz_result: got %h want 0", bus.result_o); end
        release_start();
        checks++; if (bus.ready_o !== 1'b0 || bus.div_by_zero_o !== 1'b0) begin errors++; $display("FAIL dz_clear: got ready=%b dbz=%b want 0 0", bus.ready_o, bus.div_by_zero_o); end
    endtask

    task automatic test_accumulate();
        // MADD 5 + (-3*4) = -7
        drive(OP_MADD, 32'hFFFF_FFFD, 32'd4, 64'd5);
        tick();
        tick();
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL madd_early: got %b want 0 at t+2", bus.ready_o); end
        tick();
        checks++; if (bus.ready_o !== 1'b1 || bus.result_o !== 64'hFFFFFFFF_FFFFFFF9) begin errors++; $display("FAIL madd: got %b %h want 1 fffffffffffffff9", bus.ready_o, bus.result_o); end
        release_start();
        // MSUBU 0x1_00000000 - 2*3
        drive(OP_MSUBU, 32'd2, 32'd3, 64'h00000001_00000000);
        tick(); tick(); tick();
        checks++; if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000000_FFFFFFFA) begin errors++; $display("FAIL msubu: got %b %h want 1 00000000fffffffa", bus.ready_o, bus.result_o); end
        release_start();
    endtask

    task automatic test_back_to_back();
        int lat;
        drive(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        wait_ready(10, lat);
        checks++; if (lat != 3 || bus.result_o !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL maddu_max: got lat=%0d %h want lat=3 fffffffe00000001", lat, bus.result_o); end
        release_start();
        // (-1)*(-1)=1; 0-1
        drive(OP_MSUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        wait_ready(10, lat);
        checks++; if (lat != 3 || bus.result_o !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL msub_m1: got lat=%0d %h want lat=3 ffffffffffffffff", lat, bus.result_o); end
        release_start();
    endtask

    task automatic test_annul();
        int  lat;
        logic seen;
        drive(OP_DIV, 32'h7FFF_FFFF, 32'd7, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        checks++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL annul_idle: got busy=%b ready=%b want 0 0", bus.busy_o, bus.ready_o); end
        bus.annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL annul_no_ready: got ready=%b want 0", seen); end
        // Annul in IDLE blocks acceptance.
        bus.annul_i = 1'b1;
        drive(OP_DIVU, 32'd9, 32'd3, 64'd0);
        #1;
        checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL annul_block_stall: got %b want 0", bus.stallreq_o); end
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL annul_block_busy: got %b want 0", bus.busy_o); end
        bus.annul_i = 1'b0;
        // Now accepted; operands changed afterwards must be ignored.
        tick();
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd0;
        wait_ready(40, lat);
        checks++; if (lat != exp_div_lat(32'd9) - 1 || bus.result_o !== 64'h00000000_00000003) begin errors++; $display("FAIL divu_9_3: got lat=%0d %h want lat=%0d 0000000000000003", lat, bus.result_o, exp_div_lat(32'd9) - 1); end
        release_start();
    endtask

    task automatic test_invalid_op();
        drive(3'd7, 32'd1, 32'd1, 64'd0);
        #1;
        checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL invalid_stall: got %b want 0", bus.stallreq_o); end
        tick();
        checks++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL invalid_busy: got busy=%b ready=%b want 0 0", bus.busy_o, bus.ready_o); end
        release_start();
    endtask

    task automatic test_rst_mid();
        int lat;
        drive(OP_MADD, 32'd6, 32'd7, 64'd1);
        tick();
        rst = 1'b1;
        bus.start_i = 1'b0;
        tick();
        checks++; if ({bus.busy_o, bus.ready_o, bus.div_by_zero_o, bus.stallreq_o} !== 4'b0 || bus.result_o !== 64'd0) begin errors++; $display("FAIL rst_mid_madd: got %b %h want 0000 0", {bus.busy_o, bus.ready_o, bus.div_by_zero_o, bus.stallreq_o}, bus.result_o); end
        rst = 1'b0;
        tick();
        // Reset with a result held in END.
        drive(OP_MADD, 32'd6, 32'd7, 64'd1);
        wait_ready(10, lat);
        checks++; if (bus.result_o !== 64'd43) begin errors++; $display("FAIL madd_6_7: got %h want 2b", bus.result_o); end
        rst = 1'b1;
        bus.start_i = 1'b0;
        tick();
        checks++; if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin errors++; $display("FAIL rst_end: got %b %h want 0 0", bus.ready_o, bus.result_o); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.op_i      = 3'd0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.hilo_i    = '0;
        bus.annul_i   = 1'b0;
        test_reset();
        test_div_signed();
        test_divu();
        test_div_zero();
        test_accumulate();
        test_back_to_back();
        test_annul();
        test_invalid_op();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle arithmetic companion to the execute stage. Runs DIV/DIVU (iterative, radix-2 restoring) and MADD/MADDU/MSUB/MSUBU (multiply then accumulate into HI/LO).
- Execute stage raises start_i and holds it with stable operands until ready_o. The block drives stallreq_o to freeze the pipeline meanwhile.
- Result is {hi,lo}, which execute forwards to its hi_o/lo_o/whilo_o path.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start_i  in  1  request; held high until ready_o is seen.
- op_i  in  3  operation code, encodings from muldiv_pkg: DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- opdata1_i  in  WIDTH  dividend / multiplicand.
- opdata2_i  in  WIDTH  divisor / multiplier.
- hilo_i  in  2*WIDTH  forwarded {HI,LO} accumulator; sampled in ACC.
- annul_i  in  1  flush (exception or branch); aborts operation.
- result_o  out  2*WIDTH  divide: {remainder, quotient}; accumulate: new {HI,LO}.
- ready_o  out  1  result valid.
- div_by_zero_o  out  1  qualifies result_o when ready_o is high.
- busy_o  out  1  state is DIV_ON, DIV_ZERO, MUL or ACC.
- stallreq_o  out  1  busy_o OR (state==IDLE and start_i and not annul_i); combinational.

Behaviour:
- Reset: state=IDLE; result_o=0; ready_o=0; div_by_zero_o=0; counter=0. A reset mid-operation discards all work.
- States: IDLE, DIV_ZERO, DIV_ON, MUL, ACC, END.
- IDLE, on start_i and not annul_i:
  - divide with opdata2_i==0 -> DIV_ZERO.
  - other divide -> DIV_ON. Load magnitudes (signed op with MSB set: two's-complement negate); record sign of dividend and sign of quotient.
  - accumulate op -> MUL.
  - invalid op_i -> stay IDLE; stallreq_o is 0.
- DIV_ON:
  - One restoring step per cycle: shift partial remainder left 1 and bring in next dividend bit. If partial >= divisor magnitude, subtract and set quotient bit to 1.
  - WIDTH steps, counter 0..WIDTH-1, then -> END.
  - On the END transition: quotient negated if the two signs differ (signed only); remainder takes dividend sign.
- DIV_ZERO: one cycle -> END; result_o=0, div_by_zero_o=1.
- MUL: register 2*WIDTH product of magnitudes (signed ops); negate if signs differ.
- ACC:
  - MADD/MADDU: result = hilo_i + product.
  - MSUB/MSUBU: result = hilo_i - product.
  - Modulo 2**(2*WIDTH), no overflow flag. Then -> END.
- END:
  - ready_o=1; result_o and div_by_zero_o held stable.
  - When start_i falls -> IDLE; ready_o, result_o and div_by_zero_o clear to 0 on that edge.
- Latency, with start accepted in IDLE at cycle t:
  - divide: ready_o first high at t+WIDTH+1.
  - divide by zero: t+2.
  - accumulate: t+3.
- annul_i:
  - in any busy state or END: -> IDLE next cycle; ready_o 0; no result delivered.
  - in IDLE: blocks acceptance.
- Operands are sampled only on acceptance; later changes are ignored.
- New request: requires start_i to deassert for at least one cycle after END.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined:
  - On divide acceptance, compute z = leading-zero count of dividend magnitude.
  - Pre-shift the dividend left by z and preload counter with z.
  - Iterations = max(1, WIDTH - z); ready at t+max(1,WIDTH-z)+1. Results bit-identical.
- Undefined: always WIDTH iterations, and no CLZ logic is instantiated.

Decomposition:
- muldiv_pkg: op encodings (3-bit), state encoding, default WIDTH.
- One sub-module, muldiv_clz: parametrised leading-zero counter, WIDTH in, CNT_W out; output WIDTH for an all-zero input. Instantiated only under MULDIV_EARLY_TERM_EN.

Test Plan:
- DIV 7 / 0xFFFFFFFE (-2), WIDTH=32, feature off -> result_o={0x00000001, 0xFFFFFFFD}; ready_o at t+33; stallreq_o high t..t+32.
- DIVU 0xFFFFFFFF / 0x10 -> {0x0000000F, 0x0FFFFFFF}. With MULDIV_EARLY_TERM_EN, DIVU 5/2 -> {1,2}, ready at t+4.
- DIV x / 0 -> result_o=0, div_by_zero_o=1, ready at t+2; both clear the cycle after start_i falls.
- MADD hilo_i=0x0000000000000005, -3*4 -> 0xFFFFFFFFFFFFFFF9 at t+3.
- MSUBU hilo_i=0x0000000100000000, 2*3 -> 0x00000000FFFFFFFA at t+3.
- annul_i at t+10 of a DIV -> IDLE at t+11, ready_o never asserts. A following DIVU 9/3 completes with {0,3}. rst asserted mid-MADD -> all outputs 0 next cycle.
